// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the iterative shift-and-add multiplier.
package shift_add_multiplier_pkg;

  // Controller states; encodings are fixed so the ALU can decode them.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Product width for a given operand width.
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  localparam int DEFAULT_PROD_WIDTH = prod_width(DEFAULT_WIDTH);

endpackage

// File: rtl/shift_add_multiplier_ripple_adder.sv
// Full-adder cell and the WIDTH-bit ripple-carry adder used on the acc+mcand path.
import shift_add_multiplier_pkg::*;

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  // One-bit full adder.
  always_comb begin
    sum       = a ^ b ^ carry_in;
    carry_out = (a & b) | (carry_in & (a ^ b));
  end

endmodule

module ripple_adder_nbit #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH:0] carry;

  assign carry[0]  = carry_in;
  assign carry_out = carry[WIDTH];

  // Chain of full-adder cells, LSB first.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_fa (
      .a         (a[i]),
      .b         (b[i]),
      .carry_in  (carry[i]),
      .sum       (sum[i]),
      .carry_out (carry[i+1])
    );
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one multiplier bit per clock,
// product registered and flagged with a one-cycle done pulse.
import shift_add_multiplier_pkg::*;

module shift_add_multiplier #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             A_input,
  input  logic [WIDTH-1:0]             B_input,
  output logic [prod_width(WIDTH)-1:0] product,
  output logic                         busy,
  output logic                         done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  mul_state_t       state, state_next;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic [WIDTH:0]   acc_shift;
  logic [WIDTH-1:0] mplier_shift;
  logic             accept;
  logic             last_iter;

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_iter = (state == RUN) && (count == LAST_COUNT);

  ripple_adder_nbit #(.WIDTH(WIDTH)) u_adder (
    .a         (acc[WIDTH-1:0]),
    .b         (mcand),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_carry)
  );

  // One iteration: optionally add mcand, then shift {acc,mplier} right by one.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_shift    = {1'b0, acc[WIDTH:1]};
    mplier_shift = {acc[0], mplier[WIDTH-1:1]};
    if (mplier[0]) begin
      acc_shift    = {1'b0, add_carry, add_sum[WIDTH-1:1]};
      mplier_shift = {add_sum[0], mplier[WIDTH-1:1]};
    end
  end

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered status flags.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: every register, including the operand/shift registers, is cleared on reset
  //       so an aborted operation leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mplier  <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      if (accept) begin
        mcand  <= A_input;
        mplier <= B_input;
        acc    <= '0;
        count  <= '0;
      end else if (state == RUN) begin
        acc    <= acc_shift;
        mplier <= mplier_shift;
        count  <= count + 1'b1;
        if (last_iter) product <= {acc_shift[WIDTH-1:0], mplier_shift};
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at WIDTH=4 and WIDTH=8.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [7:0]  product4;
  logic [15:0] product8;
  logic        busy4, busy8, done4, done8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A_input(a4), .B_input(b4),
    .product(product4), .busy(busy4), .done(done4)
  );

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A_input(a8), .B_input(b8),
    .product(product8), .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic [15:0] get_product(input int w);
    return (w == 4) ? {8'h00, product4} : product8;
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      start4 = s; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = s; a8 = a; b8 = b;
    end
  endtask

  // Issue one operation, check busy for w cycles, then done and the product.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string tag);
    @(negedge clk);
    drive(w, 1'b1, a, b);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      drive(w, 1'b0, a, b);
      check({tag, "_busy"}, 16'(get_busy(w)), 16'd1);
      check({tag, "_nodone"}, 16'(get_done(w)), 16'd0);
    end
    @(negedge clk);
    check({tag, "_done"}, 16'(get_done(w)), 16'd1);
    check({tag, "_busy_low"}, 16'(get_busy(w)), 16'd0);
    check({tag, "_product"}, get_product(w), exp);
  endtask

  initial begin
    int dcnt;
    rst = 1'b1;
    drive(4, 1'b0, 8'h0, 8'h0);
    drive(8, 1'b0, 8'h0, 8'h0);
    repeat (2) @(negedge clk);
    check("rst_product4", get_product(4), 16'h0);
    check("rst_busy4", 16'(busy4), 16'd0);
    check("rst_done4", 16'(done4), 16'd0);
    check("rst_product8", get_product(8), 16'h0);
    rst = 1'b0;

    // Maximum operands, then product held after done drops.
    run_op(4, 8'hF, 8'hF, 16'h00E1, "w4_ff");
    @(negedge clk);
    check("w4_ff_done_drop", 16'(done4), 16'd0);
    check("w4_ff_hold", get_product(4), 16'h00E1);

    // Zero operands and unity multiplier.
    run_op(4, 8'h0, 8'hB, 16'h0000, "w4_0xb");
    run_op(4, 8'h7, 8'h1, 16'h0007, "w4_7x1");
    run_op(4, 8'h1, 8'h0, 16'h0000, "w4_1x0");

    // Processor-width build.
    run_op(8, 8'hFF, 8'hFF, 16'hFE01, "w8_ffxff");
    run_op(8, 8'h12, 8'h34, 16'h03A8, "w8_12x34");

    // Start pulsed mid-RUN must be ignored.
    @(negedge clk);
    drive(4, 1'b1, 8'h3, 8'h5);
    @(negedge clk);
    drive(4, 1'b0, 8'h3, 8'h5);
    @(negedge clk);
    drive(4, 1'b1, 8'hF, 8'hF);
    @(negedge clk);
    drive(4, 1'b0, 8'hF, 8'hF);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4) dcnt++;
      @(negedge clk);
    end
    check("midrun_done_count", 16'(dcnt), 16'd1);
    check("midrun_product", get_product(4), 16'h000F);

    // Start held high: back-to-back issue from DONE.
    drive(4, 1'b1, 8'h9, 8'h6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_busy1", 16'(busy4), 16'd1);
    end
    @(negedge clk);
    check("b2b_done1", 16'(done4), 16'd1);
    check("b2b_busy_low1", 16'(busy4), 16'd0);
    check("b2b_product1", get_product(4), 16'h0036);
    drive(4, 1'b1, 8'h2, 8'h3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_busy2", 16'(busy4), 16'd1);
      check("b2b_nodone2", 16'(done4), 16'd0);
    end
    @(negedge clk);
    drive(4, 1'b0, 8'h2, 8'h3);
    check("b2b_done2", 16'(done4), 16'd1);
    check("b2b_product2", get_product(4), 16'h0006);

    // Reset mid-RUN discards the operation.
    run_op(4, 8'h5, 8'h5, 16'h0019, "pre_rst");
    @(negedge clk);
    drive(4, 1'b1, 8'hA, 8'hA);
    @(negedge clk);
    drive(4, 1'b0, 8'hA, 8'hA);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_product", get_product(4), 16'h0);
    check("midrst_busy", 16'(busy4), 16'd0);
    check("midrst_done", 16'(done4), 16'd0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done4 || busy4) dcnt++;
    end
    check("midrst_quiet", 16'(dcnt), 16'd0);
    run_op(4, 8'h3, 8'h4, 16'h000C, "post_rst");

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1;
    drive(4, 1'b1, 8'h7, 8'h7);
    @(negedge clk);
    rst = 1'b0;
    drive(4, 1'b0, 8'h7, 8'h7);
    check("rst_start_busy", 16'(busy4), 16'd0);
    check("rst_start_product", get_product(4), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
